// File: rtl/rgb_breath_sequencer.sv
// rgb_breath_sequencer: breathes through a colour palette, producing per-channel duty values and PWM waveforms.
module rgb_breath_sequencer #(
    parameter int DUTY_W = 8,
    parameter int NUM_COLORS = 7,
    parameter logic [3*DUTY_W*NUM_COLORS-1:0] PALETTE = {24'hA020F0, 24'h082E54, 24'h0000FF,
        24'h00FF00, 24'hFFFF00, 24'hFF3C00, 24'hFF0000},
    parameter int TICK_DIV = 625000,
    parameter int HOLD_TICKS = 0,
    localparam int CW = NUM_COLORS > 1 ? $clog2(NUM_COLORS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pause,
    input  logic              mode,
    input  logic [CW-1:0]     color_sel,
    output logic [DUTY_W-1:0] r_duty,
    output logic [DUTY_W-1:0] g_duty,
    output logic [DUTY_W-1:0] b_duty,
    output logic              r_pwm,
    output logic              g_pwm,
    output logic              b_pwm,
    output logic [CW-1:0]     color_idx,
    output logic              cycle_done
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int HW = HOLD_TICKS > 0 ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [DUTY_W-1:0] LMAX = '1;
    typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN} state_t;
    state_t state, state_n;
    logic [DUTY_W-1:0] level, level_n, pcnt;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [PW-1:0] presc, presc_n;
    logic [CW-1:0] idx_n, sel_idx, adv_idx;
    logic done_n, tick, wrap;
    logic [DUTY_W-1:0] peak [3];
    logic [DUTY_W-1:0] duty [3];
    logic [DUTY_W-1:0] lat [3];
    logic [2:0] pwm;

    assign sel_idx = 32'(color_sel) >= NUM_COLORS ? '0 : color_sel;
    assign wrap = color_idx == CW'(NUM_COLORS - 1);
    assign adv_idx = mode ? sel_idx : wrap ? '0 : color_idx + 1'b1;
    assign tick = !pause && presc == PW'(TICK_DIV - 1);

    always_comb begin
        state_n = state;
        level_n = level;
        hold_n = hold_cnt;
        presc_n = presc;
        idx_n = color_idx;
        done_n = 1'b0;
        if (!en) begin
            state_n = IDLE;
            level_n = '0;
            hold_n = '0;
            presc_n = '0;
        end else if (state == IDLE) begin
            state_n = RAMP_UP;
            level_n = '0;
            idx_n = sel_idx;
        end else if (!pause) begin
            presc_n = tick ? '0 : presc + 1'b1;
            if (tick) begin
                case (state)
                    RAMP_UP: begin
                        level_n = level + 1'b1;
                        hold_n = '0;
                        if (level == LMAX - 1'b1) state_n = HOLD_TICKS == 0 ? RAMP_DOWN : HOLD;
                    end
                    HOLD: begin
                        hold_n = hold_cnt + 1'b1;
                        if (32'(hold_cnt) + 1 == HOLD_TICKS) state_n = RAMP_DOWN;
                    end
                    RAMP_DOWN: begin
                        level_n = level - 1'b1;
                        if (level == DUTY_W'(1)) begin
                            state_n = RAMP_UP;
                            idx_n = adv_idx;
                            done_n = !mode && wrap;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            level <= '0;
            hold_cnt <= '0;
            presc <= '0;
            color_idx <= '0;
            cycle_done <= 1'b0;
        end else begin
            state <= state_n;
            level <= level_n;
            hold_cnt <= hold_n;
            presc <= presc_n;
            color_idx <= idx_n;
            cycle_done <= done_n;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) peak[i] = PALETTE[3*DUTY_W*color_idx + DUTY_W*(2-i) +: DUTY_W];
    end

    // Full level is special-cased so the peak colour is reproduced exactly rather than scaled by (2^W-1)/2^W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            pwm <= '0;
            for (int i = 0; i < 3; i++) begin
                duty[i] <= '0;
                lat[i] <= '0;
            end
        end else begin
            pcnt <= pcnt == LMAX - 1'b1 ? '0 : pcnt + 1'b1;
            for (int i = 0; i < 3; i++) begin
                duty[i] <= level == LMAX ? peak[i] : DUTY_W'(((2*DUTY_W)'(peak[i]) * level) >> DUTY_W);
                if (pcnt == '0) lat[i] <= duty[i];
                pwm[i] <= pcnt < (pcnt == '0 ? duty[i] : lat[i]);
            end
        end
    end

    assign r_duty = duty[0];
    assign g_duty = duty[1];
    assign b_duty = duty[2];
    assign r_pwm = pwm[0];
    assign g_pwm = pwm[1];
    assign b_pwm = pwm[2];
endmodule
